// File: rtl/s27_bist_pkg.sv
// Shared types and constants for the s27 BIST controller: FSM state
// encoding, pattern-generator taps, signature polynomial and the
// initialization pattern that drives s27's unreset flops to a known state.
package s27_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_INIT = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Feedback taps on bits 7,5,4,3 give a maximal-length (255) sequence.
    localparam logic [7:0]  LFSR_TAPS   = 8'hB8;

    // CCITT polynomial x^16 + x^12 + x^5 + 1 for the signature register.
    localparam logic [15:0] SISR_POLY   = 16'h1021;

    // {G3,G2,G1,G0}: forces G5=1, G6=0, G7=1 inside s27 regardless of history.
    localparam logic [3:0]  INIT_PAT    = 4'b1011;
    localparam int unsigned INIT_CYCLES = 2;

    // One step of the pattern generator: shift left, feedback into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/s27_bist.sv
// The controller top lives in s27_bist_ctrl.sv.
// This file carries the elaboration-time parameter guard shared by the top.
module s27_bist_param_check #(
    parameter int          N_PATTERNS = 255,
    parameter logic [7:0]  SEED       = 8'h01
) ();

    // Reject parameter sets the controller cannot run correctly.
    if (SEED == 8'h00) begin : g_bad_seed
        $error("s27_bist_ctrl: SEED must be nonzero");
    end
    if (N_PATTERNS < 1 || N_PATTERNS > 65535) begin : g_bad_count
        $error("s27_bist_ctrl: N_PATTERNS must be in 1..65535");
    end

endmodule

// File: rtl/s27_sisr.sv
// 16-bit serial-input signature register. Compacts one response bit per
// enabled cycle; clear has priority over shift.
module s27_sisr
    import s27_bist_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] sig
);

    // Galois-style update: feedback is the outgoing MSB xor the new bit.
    always_ff @(posedge clk) begin
        if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[14:0], 1'b0} ^ ({16{sig[15] ^ din}} & SISR_POLY);
        end
    end

endmodule

// File: rtl/s27_bist_ctrl.sv
// BIST controller around the s27 core: LFSR stimulus on G0..G3, SISR
// compaction of G17, start/done handshake and golden-signature pass flag.
module s27_bist_ctrl
    import s27_bist_pkg::*;
#(
    parameter int          N_PATTERNS = 255,
    parameter logic [7:0]  SEED       = 8'h01,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        start,
    input  logic        G17,
    output logic        G0,
    output logic        G1,
    output logic        G2,
    output logic        G3,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    localparam logic [15:0] RUN_LAST  = 16'(N_PATTERNS - 1);
    localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);

    s27_bist_param_check #(
        .N_PATTERNS (N_PATTERNS),
        .SEED       (SEED)
    ) u_param_check ();

    state_t      state;
    logic [7:0]  lfsr;
    logic [7:0]  lfsr_adv;
    logic [15:0] cnt;
    logic [3:0]  pat;
    logic        launch;
    logic        sisr_clr;
    logic        sisr_en;

    // Handshake decode and SISR control; launch is a full reload request.
    always_comb begin
        lfsr_adv = lfsr_next(lfsr);
        launch   = ((state == ST_IDLE) || (state == ST_DONE)) && start;
        sisr_clr = RST || launch;
        sisr_en  = (state == ST_RUN);
    end

    // FSM, pattern generator, cycle counter and registered pattern/status outputs.
    always_ff @(posedge CK) begin
        if (RST) begin
            state <= ST_IDLE;
            lfsr  <= SEED;
            cnt   <= '0;
            pat   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_INIT;
                        lfsr  <= SEED;
                        cnt   <= '0;
                        pat   <= INIT_PAT;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                ST_INIT: begin
                    if (cnt == INIT_LAST) begin
                        // First RUN pattern is the freshly loaded seed itself.
                        state <= ST_RUN;
                        cnt   <= '0;
                        pat   <= lfsr[3:0];
                    end else begin
                        cnt   <= cnt + 16'd1;
                    end
                end
                ST_RUN: begin
                    lfsr <= lfsr_adv;
                    if (cnt == RUN_LAST) begin
                        state <= ST_DONE;
                        pat   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        // Register the next pattern so it is valid for the whole next cycle.
                        cnt   <= cnt + 16'd1;
                        pat   <= lfsr_adv[3:0];
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    pat   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    s27_sisr u_sisr (
        .clk (CK),
        .clr (sisr_clr),
        .en  (sisr_en),
        .din (G17),
        .sig (signature)
    );

    assign {G3, G2, G1, G0} = pat;
    assign pass = done && (signature == GOLDEN_SIG);

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Self-checking bench for s27_bist_ctrl: several parameterizations share
// clock, reset and start; a behavioural s27 closes the loop on the N=255 copy.
module tb_s27_bist_ctrl;

    localparam logic [7:0] SEED_V = 8'h01;

    int checks   = 0;
    int failures = 0;

    logic CK    = 1'b0;
    logic RST   = 1'b1;
    logic start = 1'b0;

    always #5 CK = ~CK;

    // ---------------- reference model helpers ----------------
    function automatic logic [7:0] ref_lfsr(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [15:0] ref_sisr(input logic [15:0] s, input logic b);
        logic [15:0] shifted;
        shifted = (s << 1) & 16'hFFFF;
        return ((s >> 15) != {15'd0, b}) ? (shifted ^ 16'h1021) : shifted;
    endfunction

    // s27 netlist: returns {G17, next G7, next G6, next G5}; st = {G7,G6,G5}.
    function automatic logic [3:0] s27_step(input logic [3:0] g, input logic [2:0] st,
                                            input logic flt);
        logic g5, g6, g7, g8, g9, g10, g11, g12, g13, g14, g15, g16;
        g5  = st[0]; g6 = st[1]; g7 = st[2];
        g14 = ~g[0];
        g12 = ~(g[1] | g7);
        g8  = g14 & g6;
        g15 = g12 | g8;
        g16 = g[3] | g8;
        g9  = ~(g16 & g15);
        g11 = flt ? 1'b0 : ~(g5 | g9);
        g10 = ~(g14 | g11);
        g13 = ~(g[2] | g12);
        return {~g11, g13, g11, g10};
    endfunction

    // Whole closed-loop BIST session computed from the rules, no RTL state.
    function automatic logic [15:0] closed_loop_sig(input logic flt);
        logic [2:0]  st;
        logic [3:0]  r;
        logic [7:0]  l;
        logic [15:0] s;
        st = 3'b000; l = SEED_V; s = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            r  = s27_step(4'b1011, st, flt);
            st = r[2:0];
        end
        for (int k = 0; k < 255; k++) begin
            r  = s27_step(l[3:0], st, flt);
            s  = ref_sisr(s, r[3]);
            st = r[2:0];
            l  = ref_lfsr(l);
        end
        return s;
    endfunction

    localparam logic [15:0] GOLD = closed_loop_sig(1'b0);

    // ---------------- DUT instances ----------------
    logic [3:0]  n4_pat, n1_pat, n2_pat, n255_pat;
    logic        n4_busy, n4_done, n4_pass;
    logic        n1_busy, n1_done, n1_pass;
    logic        n2_busy, n2_done, n2_pass;
    logic        n255_busy, n255_done, n255_pass;
    logic [15:0] n4_sig, n1_sig, n2_sig, n255_sig;
    logic        g17_n4    = 1'b0;
    logic        g17_small = 1'b0;
    logic        g17_n255;
    logic [1:0]  mode      = 2'd0;   // 0: G17 tied 0, 1: s27, 2: s27 with G11 s-a-0
    logic        fault     = 1'b0;
    logic [2:0]  s27_st    = 3'b000;
    logic [3:0]  s27_r;

    s27_bist_ctrl #(.N_PATTERNS(4), .SEED(SEED_V), .GOLDEN_SIG(16'h0000)) u_n4 (
        .CK(CK), .RST(RST), .start(start), .G17(g17_n4),
        .G0(n4_pat[0]), .G1(n4_pat[1]), .G2(n4_pat[2]), .G3(n4_pat[3]),
        .busy(n4_busy), .done(n4_done), .pass(n4_pass), .signature(n4_sig));

    s27_bist_ctrl #(.N_PATTERNS(1), .SEED(SEED_V), .GOLDEN_SIG(16'h0000)) u_n1 (
        .CK(CK), .RST(RST), .start(start), .G17(g17_small),
        .G0(n1_pat[0]), .G1(n1_pat[1]), .G2(n1_pat[2]), .G3(n1_pat[3]),
        .busy(n1_busy), .done(n1_done), .pass(n1_pass), .signature(n1_sig));

    s27_bist_ctrl #(.N_PATTERNS(2), .SEED(SEED_V), .GOLDEN_SIG(16'h0000)) u_n2 (
        .CK(CK), .RST(RST), .start(start), .G17(g17_small),
        .G0(n2_pat[0]), .G1(n2_pat[1]), .G2(n2_pat[2]), .G3(n2_pat[3]),
        .busy(n2_busy), .done(n2_done), .pass(n2_pass), .signature(n2_sig));

    s27_bist_ctrl #(.N_PATTERNS(255), .SEED(SEED_V), .GOLDEN_SIG(GOLD)) u_n255 (
        .CK(CK), .RST(RST), .start(start), .G17(g17_n255),
        .G0(n255_pat[0]), .G1(n255_pat[1]), .G2(n255_pat[2]), .G3(n255_pat[3]),
        .busy(n255_busy), .done(n255_done), .pass(n255_pass), .signature(n255_sig));

    // Behavioural s27 core downstream of the N=255 controller.
    always_comb s27_r = s27_step(n255_pat, s27_st, fault);
    always @(posedge CK) s27_st <= s27_r[2:0];
    always_comb g17_n255 = (mode == 2'd0) ? 1'b0 : s27_r[3];

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        start = 1'b0;
        RST   = 1'b1;
        repeat (2) @(negedge CK);
        RST   = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge CK) start = 1'b1;
        @(negedge CK) start = 1'b0;
    endtask

    task automatic wait_n255_done(input int budget);
        int n;
        n = 0;
        while (n255_done !== 1'b1 && n < budget) begin
            @(negedge CK);
            n++;
        end
        checks++;
        if (n255_done !== 1'b1) begin
            failures++;
            $display("FAIL n255_done_timeout: done=%b after %0d cycles, required 1", n255_done, n);
        end
    endtask

    // One N=4 session from IDLE/DONE, cycle-by-cycle against the model.
    task automatic run_n4(input logic [3:0] bits, input bit noise, input bit chk_clear,
                          output logic [15:0] got);
        logic [7:0]  l;
        logic [15:0] m;
        logic [3:0]  exp_pat;
        l = SEED_V;
        m = 16'h0000;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge CK);
            start   = (noise && (i == 0 || i == 3 || i == 5)) ? 1'b1 : 1'b0;
            exp_pat = (i < 2) ? 4'b1011 : l[3:0];
            checks++;
            if (n4_pat !== exp_pat || n4_busy !== 1'b1 || n4_done !== 1'b0) begin
                failures++;
                $display("FAIL n4_cycle%0d: pat=%b busy=%b done=%b, required pat=%b busy=1 done=0",
                         i, n4_pat, n4_busy, n4_done, exp_pat);
            end
            if (chk_clear && i < 2) begin
                checks++;
                if (n4_sig !== 16'h0000) begin
                    failures++;
                    $display("FAIL n4_restart_clear: sig=%h, required 0000", n4_sig);
                end
            end
            if (i >= 2) begin
                g17_n4 = bits[i-2];
                m      = ref_sisr(m, bits[i-2]);
                l      = ref_lfsr(l);
            end
        end
        @(negedge CK);
        start = 1'b0;
        checks++;
        if (n4_done !== 1'b1 || n4_busy !== 1'b0 || n4_pat !== 4'b0000 ||
            n4_sig !== m || n4_pass !== (m == 16'h0000)) begin
            failures++;
            $display("FAIL n4_done: done=%b busy=%b pat=%b sig=%h pass=%b, required 1 0 0000 %h %b",
                     n4_done, n4_busy, n4_pat, n4_sig, n4_pass, m, (m == 16'h0000));
        end
        got = n4_sig;
    endtask

    // ---------------- scenario tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({n4_pat, n4_busy, n4_done, n4_pass, n4_sig} !== '0) begin
            failures++;
            $display("FAIL reset_state: pat=%b busy=%b done=%b pass=%b sig=%h, required all 0",
                     n4_pat, n4_busy, n4_done, n4_pass, n4_sig);
        end
        checks++;
        if ({n255_pat, n255_busy, n255_done, n255_sig} !== '0) begin
            failures++;
            $display("FAIL reset_n255: pat=%b busy=%b done=%b sig=%h, required all 0",
                     n255_pat, n255_busy, n255_done, n255_sig);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge CK);
            checks++;
            if ({n4_pat, n4_busy, n4_done, n4_sig} !== '0) begin
                failures++;
                $display("FAIL idle_hold%0d: pat=%b busy=%b done=%b sig=%h, required all 0",
                         i, n4_pat, n4_busy, n4_done, n4_sig);
            end
        end
    endtask

    task automatic test_pattern();
        logic [15:0] s;
        do_reset();
        run_n4(4'($urandom), 1'b0, 1'b0, s);
    endtask

    task automatic test_sisr();
        do_reset();
        mode      = 2'd0;
        fault     = 1'b0;
        g17_small = 1'b1;
        pulse_start();
        wait_n255_done(400);
        checks++;
        if (n1_done !== 1'b1 || n1_sig !== 16'h1021) begin
            failures++;
            $display("FAIL sisr_n1: done=%b sig=%h, required 1 1021", n1_done, n1_sig);
        end
        checks++;
        if (n2_done !== 1'b1 || n2_sig !== 16'h3063) begin
            failures++;
            $display("FAIL sisr_n2: done=%b sig=%h, required 1 3063", n2_done, n2_sig);
        end
        checks++;
        if (n255_sig !== 16'h0000 || n255_pass !== (GOLD == 16'h0000)) begin
            failures++;
            $display("FAIL sisr_zero: sig=%h pass=%b, required 0000 %b",
                     n255_sig, n255_pass, (GOLD == 16'h0000));
        end
        g17_small = 1'b0;
    endtask

    task automatic test_handshake();
        logic [3:0]  bits;
        logic [15:0] s1, s2, s3;
        do_reset();
        bits = 4'($urandom);
        run_n4(bits, 1'b1, 1'b0, s1);
        run_n4(bits, 1'b0, 1'b1, s2);
        run_n4(bits, 1'b1, 1'b1, s3);
        checks++;
        if (s2 !== s1 || s3 !== s1) begin
            failures++;
            $display("FAIL repeat_run: sig=%h,%h, required %h", s2, s3, s1);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        mode  = 2'd1;
        fault = 1'b0;
        pulse_start();
        repeat (5) @(negedge CK);
        RST = 1'b1;
        @(negedge CK);
        checks++;
        if ({n255_pat, n255_busy, n255_done, n255_pass, n255_sig} !== '0) begin
            failures++;
            $display("FAIL mid_run_reset: pat=%b busy=%b done=%b pass=%b sig=%h, required all 0",
                     n255_pat, n255_busy, n255_done, n255_pass, n255_sig);
        end
        RST = 1'b0;
        pulse_start();
        wait_n255_done(400);
        checks++;
        if (n255_sig !== GOLD || n255_pass !== 1'b1) begin
            failures++;
            $display("FAIL closed_loop: sig=%h pass=%b, required %h 1", n255_sig, n255_pass, GOLD);
        end
    endtask

    task automatic test_fault();
        logic [15:0] exp;
        exp = closed_loop_sig(1'b1);
        do_reset();
        mode  = 2'd2;
        fault = 1'b1;
        pulse_start();
        wait_n255_done(400);
        checks++;
        if (n255_sig !== exp || n255_pass !== (exp == GOLD)) begin
            failures++;
            $display("FAIL g11_stuck0: sig=%h pass=%b, required %h %b",
                     n255_sig, n255_pass, exp, (exp == GOLD));
        end
        checks++;
        if (n255_pass !== 1'b0) begin
            failures++;
            $display("FAIL g11_stuck0_pass: pass=%b, required 0", n255_pass);
        end
        fault = 1'b0;
        mode  = 2'd0;
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_sisr();
        test_handshake();
        test_reset_mid_run();
        test_fault();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/s27_bist_ctrl.md
# s27_bist_ctrl

Built-in self-test controller that wraps the s27 benchmark core. It sits upstream of s27, driving G0–G3 from an 8-bit LFSR pattern generator, and downstream of it, compacting the G17 response into a 16-bit serial signature register (SISR). A start/done handshake runs one initialization phase, then N_PATTERNS test cycles, and reports the final signature and a pass flag against a golden value.

## Interface
- N_PATTERNS, 255: number of RUN cycles; legal range 1..65535.
- SEED, 8'h01: LFSR load value; must be nonzero.
- GOLDEN_SIG, 16'h0000: expected final signature.
- CK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle request; sampled only in IDLE and DONE.
- G17  input  1  s27 primary output, fed back for compaction.
- G0, G1, G2, G3  output  1 each  s27 primary inputs, registered.
- busy  output  1  high in INIT and RUN.
- done  output  1  high in DONE.
- pass  output  1  done && (signature == GOLDEN_SIG).
- signature  output  16  SISR contents.

## Operation
- States: IDLE, INIT, RUN, DONE.
- IDLE: outputs held at 0. start=1 → INIT; reload LFSR to SEED, clear SISR to 0, clear counter.
- INIT: 2 cycles, driving {G3,G2,G1,G0}=4'b1011. This pattern forces s27's unreset flops to the known state G5=1, G6=0, G7=1. The SISR does not shift. After cycle 2 → RUN.
- RUN: drive {G3,G2,G1,G0} = lfsr[3:0].
  - Each cycle, LFSR advances: lfsr ← {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}, with period 255.
  - Each cycle, SISR shifts in G17: sig ← {sig[14:0],1'b0} ^ ({16{sig[15]^G17}} & 16'h1021).
  - After N_PATTERNS cycles → DONE.
- DONE: G0–G3 return to 0; signature frozen; done=1. start=1 → INIT with a full reload, same as from IDLE.
- start in INIT or RUN is ignored.
- RST at any point: next state IDLE; LFSR=SEED, sig=0, counter=0; all outputs 0.
- An illegal state encoding goes to IDLE.

## Timing
- Edge E0 samples start=1: busy rises after E0. INIT occupies cycles E0–E1 and E1–E2.
- RUN cycle k (k=0..N-1) spans edges E(2+k) to E(3+k).
  - The pattern is valid throughout cycle k.
  - G17 is combinational in s27 from its current inputs and state, so it is sampled at the edge that ends cycle k.
- done=1 and busy=0 starting after edge E(2+N). The total run is 2+N cycles.
- signature is valid and stable whenever done=1. It is a don't-care while busy.
- Pattern outputs come straight from registers, with no combinational path from start.
- The counter is 16 bits, compared against N_PATTERNS-1. There is no wrap, because the range is bounded by the parameter check.

## Structure
- Package s27_bist_pkg holds:
  - the state enum;
  - LFSR taps, SISR polynomial 16'h1021, INIT_PAT 4'b1011, INIT_CYCLES 2.
- Sub-module s27_sisr holds the 16-bit serial signature register, with clear and shift-enable inputs. The LFSR, counter and FSM stay in the top level.
- An elaboration-time check rejects SEED==0 and N_PATTERNS==0.

## Test plan
- Reset: assert RST for 2 cycles → G0–G3=0, busy=0, done=0, signature=16'h0000. Hold start=0 for 10 cycles → no change.
- Start, SEED=8'h01, N=4:
  - two INIT cycles show {G3..G0}=4'b1011;
  - the four RUN cycles show lfsr 01, 02, 04, 08, i.e. {G3..G0}=0001, 0010, 0100, 1000;
  - done rises exactly 6 cycles after the start edge.
- SISR arithmetic, G17 driven by the bench:
  - G17 tied 0, N=255 → signature=16'h0000.
  - G17 tied 1, N=1 → 16'h1021.
  - G17 tied 1, N=2 → 16'h3063.
- Handshake:
  - start pulses during INIT and RUN → ignored; done timing unchanged.
  - start in DONE → restart, signature cleared, identical result on a repeated run.
- Reset mid-RUN: assert RST at RUN cycle 3 → IDLE next cycle, outputs 0. A following start produces the same signature as an uninterrupted run.
- Closed loop with the real s27 instance, N=255: record the signature, set GOLDEN_SIG to that value → pass=1. Inject a stuck-at-0 fault on G11 → pass=0.
